// File: rtl/vec_issue_queue.sv
// vec_issue_queue: in-order decoupling FIFO between the scalar core's vector
// dispatch and the CARRD vector coprocessor. Each entry holds the vector
// instruction plus the rs1/rs2 scalar values captured at dispatch. The head
// entry is presented combinationally from the storage array (first-word
// fall-through). in_ready depends only on registered occupancy.
module vec_issue_queue #(
    parameter int DEPTH      = 4,
    parameter int WORD_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [WORD_WIDTH-1:0]    in_instr,
    input  logic [WORD_WIDTH-1:0]    in_xs1,
    input  logic [WORD_WIDTH-1:0]    in_xs2,
    output logic                     in_ready,
    input  logic                     flush,
    output logic                     out_valid,
    output logic [WORD_WIDTH-1:0]    out_instr,
    output logic [WORD_WIDTH-1:0]    out_xs1,
    output logic [WORD_WIDTH-1:0]    out_xs2,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Occupancy classes derived from the count register.
    localparam logic [1:0] OCC_EMPTY   = 2'd0;
    localparam logic [1:0] OCC_PARTIAL = 2'd1;
    localparam logic [1:0] OCC_FULL    = 2'd2;

    typedef struct packed {
        logic [WORD_WIDTH-1:0] instr;
        logic [WORD_WIDTH-1:0] xs1;
        logic [WORD_WIDTH-1:0] xs2;
    } entry_t;

    entry_t            mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic [1:0]        occ;
    logic              push;
    logic              pop;
    entry_t            head;

    // Classify occupancy; handshakes and status outputs follow from it.
    always_comb begin
        // NOTE: default first so every path assigns occ and no latch is inferred.
        occ = OCC_PARTIAL;
        if (count_q == '0)
            occ = OCC_EMPTY;
        else if (count_q == CNT_W'(DEPTH))
            occ = OCC_FULL;
    end

    // A full queue refuses pushes even when the head is popped in the same
    // cycle, so in_ready never depends on out_ready.
    assign in_ready  = (occ != OCC_FULL);
    assign out_valid = (occ != OCC_EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign head      = mem[rd_ptr];
    assign out_instr = head.instr;
    assign out_xs1   = head.xs1;
    assign out_xs2   = head.xs2;
    assign count     = count_q;

    // Pointer and occupancy bookkeeping; rst beats flush, flush beats push/pop.
    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage: write the dispatched instruction and its operands.
    always_ff @(posedge clk) begin
        // NOTE: the array is intentionally not reset; count/out_valid guard stale contents.
        if (push && !flush && !rst)
            mem[wr_ptr] <= '{instr: in_instr, xs1: in_xs1, xs2: in_xs2};
    end

endmodule
